// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown core with one-second prescaler.
// Drives four BCD digits, a per-decrement tick and a sticky done flag.
module bcd_countdown_timer #(
   parameter int TICK_DIV     = 50000000,
   parameter int MAX_MIN_TENS = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic [3:0] set_min_tens,
   input  logic [3:0] set_min_ones,
   input  logic [3:0] set_sec_tens,
   input  logic [3:0] set_sec_ones,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       done,
   output logic       tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSED,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_pre;
   logic [3:0]    r_mt;
   logic [3:0]    r_mo;
   logic [3:0]    r_st;
   logic [3:0]    r_so;
   logic          r_running;
   logic          r_done;
   logic          r_tick;

   logic [3:0] w_ld_mt;
   logic [3:0] w_ld_mo;
   logic [3:0] w_ld_st;
   logic [3:0] w_ld_so;
   logic [3:0] w_mt_n;
   logic [3:0] w_mo_n;
   logic [3:0] w_st_n;
   logic [3:0] w_so_n;
   logic       w_so_b;
   logic       w_st_b;
   logic       w_mo_b;
   logic       w_zero;
   logic       w_dec_zero;
   logic       w_wrap;

   // Clamp preset digits so the counter only ever holds legal BCD
   always_comb begin
      w_ld_mt = (set_min_tens > MT_MAX) ? MT_MAX : set_min_tens;
      w_ld_mo = (set_min_ones > 4'd9) ? 4'd9 : set_min_ones;
      w_ld_st = (set_sec_tens > 4'd5) ? 4'd5 : set_sec_tens;
      w_ld_so = (set_sec_ones > 4'd9) ? 4'd9 : set_sec_ones;
   end

   // BCD borrow chain: value one second below the current digits
   always_comb begin
      w_so_b = (r_so == 4'd0);
      w_so_n = w_so_b ? 4'd9 : r_so - 4'd1;
      w_st_b = w_so_b && (r_st == 4'd0);
      w_st_n = r_st;
      if (w_so_b) begin
         w_st_n = (r_st == 4'd0) ? 4'd5 : r_st - 4'd1;
      end
      w_mo_b = w_st_b && (r_mo == 4'd0);
      w_mo_n = r_mo;
      if (w_st_b) begin
         w_mo_n = (r_mo == 4'd0) ? 4'd9 : r_mo - 4'd1;
      end
      w_mt_n = w_mo_b ? r_mt - 4'd1 : r_mt;
      w_zero = (r_mt == 4'd0) && (r_mo == 4'd0) &&
               (r_st == 4'd0) && (r_so == 4'd0);
      w_dec_zero = (w_mt_n == 4'd0) && (w_mo_n == 4'd0) &&
                   (w_st_n == 4'd0) && (w_so_n == 4'd0);
      w_wrap = (r_pre == PRE_LAST);
   end

   // Control FSM, prescaler and digit registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pre     <= '0;
         r_mt      <= 4'd0;
         r_mo      <= 4'd0;
         r_st      <= 4'd0;
         r_so      <= 4'd0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if (load) begin
            r_mt      <= w_ld_mt;
            r_mo      <= w_ld_mo;
            r_st      <= w_ld_st;
            r_so      <= w_ld_so;
            r_pre     <= '0;
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_pre <= '0;
                     if (w_zero) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                     end
                  end
               end
               S_PAUSED: begin
                  // Resume keeps the partial second already counted
                  if (start) begin
                     if (w_zero) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                     end
                  end
               end
               S_RUN: begin
                  if (pause) begin
                     r_state   <= S_PAUSED;
                     r_running <= 1'b0;
                  end else if (w_wrap) begin
                     r_pre  <= '0;
                     r_tick <= 1'b1;
                     r_mt   <= w_mt_n;
                     r_mo   <= w_mo_n;
                     r_st   <= w_st_n;
                     r_so   <= w_so_n;
                     if (w_dec_zero) begin
                        r_state   <= S_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                     end
                  end else begin
                     r_pre <= r_pre + 1'b1;
                  end
               end
               S_DONE: begin
                  r_pre <= '0;
               end
            endcase
         end
      end
   end

   assign min_tens = r_mt;
   assign min_ones = r_mo;
   assign sec_tens = r_st;
   assign sec_ones = r_so;
   assign running  = r_running;
   assign done     = r_done;
   assign tick     = r_tick;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios then random pulses,
// checked every cycle against a seconds-count reference model.
module tb_bcd_countdown_timer;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       load = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] set_min_tens = 4'd0;
   logic [3:0] set_min_ones = 4'd0;
   logic [3:0] set_sec_tens = 4'd0;
   logic [3:0] set_sec_ones = 4'd0;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running;
   logic       done;
   logic       tick;

   int checks = 0;
   int failures = 0;

   // model: remaining seconds, mode 0=idle 1=run 2=paused 3=done
   int m_total = 0;
   int m_mode = 0;
   int m_pre = 0;
   bit m_tick = 1'b0;

   bcd_countdown_timer #(.TICK_DIV(TD), .MAX_MIN_TENS(9)) dut (
      .clk(clk),
      .reset(reset),
      .load(load),
      .start(start),
      .pause(pause),
      .set_min_tens(set_min_tens),
      .set_min_ones(set_min_ones),
      .set_sec_tens(set_sec_tens),
      .set_sec_ones(set_sec_ones),
      .min_tens(min_tens),
      .min_ones(min_ones),
      .sec_tens(sec_tens),
      .sec_ones(sec_ones),
      .running(running),
      .done(done),
      .tick(tick)
   );

   always #5 clk = ~clk;

   function automatic int clampi(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [18:0] obs_vec();
      return {min_tens, min_ones, sec_tens, sec_ones, running, done, tick};
   endfunction

   function automatic logic [18:0] mk(int mm, int ss, bit r, bit d, bit t);
      logic [18:0] v;
      v = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), r, d, t};
      return v;
   endfunction

   function automatic logic [18:0] model_vec();
      return mk(m_total / 60, m_total % 60, m_mode == 1, m_mode == 3, m_tick);
   endfunction

   task automatic chk(string tag, logic [18:0] o, logic [18:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic model_step();
      int mm;
      if (reset) begin
         m_total = 0; m_mode = 0; m_pre = 0; m_tick = 0;
      end else begin
         m_tick = 0;
         if (load) begin
            mm = clampi(int'(set_min_tens), 9) * 10 +
                 clampi(int'(set_min_ones), 9);
            m_total = mm * 60 + clampi(int'(set_sec_tens), 5) * 10 +
                      clampi(int'(set_sec_ones), 9);
            m_pre = 0; m_mode = 0;
         end else if ((m_mode == 0 || m_mode == 2) && start) begin
            if (m_mode == 0) m_pre = 0;
            m_mode = (m_total == 0) ? 3 : 1;
         end else if (m_mode == 1 && pause) begin
            m_mode = 2;
         end else if (m_mode == 1) begin
            if (m_pre == TD - 1) begin
               m_pre = 0; m_total--; m_tick = 1;
               if (m_total == 0) m_mode = 3;
            end else begin
               m_pre++;
            end
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("model", obs_vec(), model_vec());
      reset = 0; load = 0; start = 0; pause = 0;
   endtask

   task automatic do_load(int mt, int mo, int st, int so);
      set_min_tens = 4'(mt); set_min_ones = 4'(mo);
      set_sec_tens = 4'(st); set_sec_ones = 4'(so);
      load = 1;
      cyc();
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      reset = 1;
      cyc();
      chk("reset", obs_vec(), 19'd0);

      // countdown from 00:12 to done
      do_load(0, 0, 1, 2);
      start = 1; cyc();
      run(TD);
      chk("t1_first", obs_vec(), mk(0, 11, 1, 0, 1));
      run(TD * 2);
      chk("t1_borrow", obs_vec(), mk(0, 9, 1, 0, 1));
      run(TD * 9);
      chk("t1_done", obs_vec(), mk(0, 0, 0, 1, 1));
      run(3);
      chk("t1_hold", obs_vec(), mk(0, 0, 0, 1, 0));

      // full borrow chain 10:00 -> 09:59
      do_load(1, 0, 0, 0);
      start = 1; cyc();
      run(TD);
      chk("t2_chain", obs_vec(), mk(9, 59, 1, 0, 1));
      cyc();
      chk("t2_tick1", obs_vec(), mk(9, 59, 1, 0, 0));

      // pause keeps partial prescaler
      do_load(0, 0, 3, 0);
      start = 1; cyc();
      run(TD + 2);
      pause = 1; cyc();
      run(20);
      chk("t3_frozen", obs_vec(), mk(0, 29, 0, 0, 0));
      start = 1; cyc();
      cyc();
      chk("t3_wait", obs_vec(), mk(0, 29, 1, 0, 0));
      cyc();
      chk("t3_resume", obs_vec(), mk(0, 28, 1, 0, 1));

      // clamping and zero start
      do_load(0, 15, 7, 12);
      chk("t4_clamp", obs_vec(), mk(9, 59, 0, 0, 0));
      do_load(0, 0, 0, 0);
      start = 1; cyc();
      chk("t4_zero", obs_vec(), mk(0, 0, 0, 1, 0));
      run(TD + 1);

      // reset dominates load/start mid-run
      do_load(0, 5, 1, 7);
      start = 1; cyc();
      run(TD + 1);
      reset = 1; load = 1; start = 1; cyc();
      chk("t5_reset", obs_vec(), 19'd0);

      // DONE ignores start/pause; load beats start
      do_load(0, 0, 0, 1);
      start = 1; cyc();
      run(TD);
      start = 1; cyc();
      pause = 1; cyc();
      chk("t6_done", obs_vec(), mk(0, 0, 0, 1, 0));
      set_min_tens = 0; set_min_ones = 1;
      set_sec_tens = 0; set_sec_ones = 0;
      load = 1; start = 1; cyc();
      chk("t6_ldst", obs_vec(), mk(1, 0, 0, 0, 0));
      run(TD + 1);
      chk("t6_idle", obs_vec(), mk(1, 0, 0, 0, 0));

      // random pulses against the model
      for (int i = 0; i < 1500; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         set_min_tens = 4'($urandom_range(0, 15));
         set_min_ones = 4'($urandom_range(0, 15));
         set_sec_tens = 4'($urandom_range(0, 15));
         set_sec_ones = 4'($urandom_range(0, 15));
         if ((r % 50) == 7 && (i % 3) == 0) set_min_tens = 4'd0;
         load  = (r < 3);
         start = (r >= 3 && r < 10) || (r == 95);
         pause = (r >= 10 && r < 14) || (r == 95);
         reset = (r == 99);
         if (load && (r == 1)) begin
            set_min_tens = 0; set_min_ones = 0; set_sec_tens = 0;
            set_sec_ones = 4'($urandom_range(0, 3));
         end
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
